// File: rtl/control_seq_if.sv
// Bus between the control sequencer (master) and the datapath it steers (slave).
interface control_seq_if #(
  parameter int OPC_W = 8,
  parameter int T_W   = 3
);
  logic [OPC_W-1:0] Instruction;
  logic             flag_z;
  logic             flag_c;
  logic             mem_ready;
  logic [1:0]       MUX_sel;
  logic [1:0]       ALU_op;
  logic             AR_load;
  logic             PC_load;
  logic             PC_inc;
  logic             AC_load;
  logic             ZC_load;
  logic             IR_load;
  logic             DR_load;
  logic             MEM_we;
  logic             halted;
  logic             illegal;
  logic [T_W-1:0]   state_count;
  logic             clear;

  modport master (
    input  Instruction, flag_z, flag_c, mem_ready,
    output MUX_sel, ALU_op, AR_load, PC_load, PC_inc, AC_load, ZC_load,
           IR_load, DR_load, MEM_we, halted, illegal, state_count, clear
  );

  modport slave (
    output Instruction, flag_z, flag_c, mem_ready,
    input  MUX_sel, ALU_op, AR_load, PC_load, PC_inc, AC_load, ZC_load,
           IR_load, DR_load, MEM_we, halted, illegal, state_count, clear
  );
endinterface

// File: rtl/control_seq.sv
// Step-counter control sequencer for an accumulator CPU; strobes decode T, opcode and flags.
// Define CTRL_COND_JUMP_EN to enable JZ/JC; otherwise opcodes 5 and 6 decode as undefined.
module control_seq #(
  parameter int OPC_W    = 8,
  parameter int T_W      = 3,
  parameter int MEM_WAIT = 1
) (
  input logic            clk,
  input logic            rst,
  control_seq_if.master  bus
);

`ifdef CTRL_COND_JUMP_EN
  localparam bit COND_JMP = 1'b1;
`else
  localparam bit COND_JMP = 1'b0;
`endif

  localparam logic [1:0] MUX_ACC = 2'b00;
  localparam logic [1:0] MUX_DR  = 2'b01;
  localparam logic [1:0] MUX_PC  = 2'b10;
  localparam logic [1:0] MUX_MEM = 2'b11;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_PAS = 2'b01;
  localparam logic [1:0] ALU_COM = 2'b11;

  logic [T_W-1:0] t_q, t_d;
  logic           halted_q, halted_d;
  logic           mem_ok, mem_step;
  logic [1:0]     mux_sel, alu_op;
  logic           ar_load, pc_load, pc_inc, ac_load, zc_load, ir_load, dr_load, mem_we;
  logic           clear, illegal;
  logic           is_lda, is_adda, is_stoa, is_jmp, is_coma, is_jz, is_jc, is_hlt;
  logic           is_cj, op_fetch, cj_take;

  assign mem_ok   = (MEM_WAIT != 0) ? bus.mem_ready : 1'b1;
  assign is_lda   = (bus.Instruction == OPC_W'(0));
  assign is_adda  = (bus.Instruction == OPC_W'(1));
  assign is_stoa  = (bus.Instruction == OPC_W'(2));
  assign is_jmp   = (bus.Instruction == OPC_W'(3));
  assign is_coma  = (bus.Instruction == OPC_W'(4));
  assign is_jz    = (bus.Instruction == OPC_W'(5)) && COND_JMP;
  assign is_jc    = (bus.Instruction == OPC_W'(6)) && COND_JMP;
  assign is_hlt   = (bus.Instruction == OPC_W'(7));
  assign is_cj    = is_jz || is_jc;
  assign op_fetch = is_lda || is_adda || is_stoa || is_jmp || is_cj;
  assign cj_take  = (is_jz && bus.flag_z) || (is_jc && bus.flag_c);

  always_comb begin
    mux_sel  = MUX_ACC;
    alu_op   = ALU_ADD;
    ar_load  = 1'b0;
    pc_load  = 1'b0;
    pc_inc   = 1'b0;
    ac_load  = 1'b0;
    zc_load  = 1'b0;
    ir_load  = 1'b0;
    dr_load  = 1'b0;
    mem_we   = 1'b0;
    clear    = 1'b0;
    illegal  = 1'b0;
    mem_step = 1'b0;
    halted_d = halted_q;
    if (!halted_q) begin
      case (t_q)
        T_W'(0): begin
          mux_sel = MUX_PC;
          ar_load = 1'b1;
        end
        T_W'(1): begin
          mem_step = 1'b1;
          if (mem_ok) begin
            mux_sel = MUX_MEM;
            dr_load = 1'b1;
            pc_inc  = 1'b1;
          end
        end
        // IR captures DR on its own path; the bus carries PC so AR points at the operand.
        T_W'(2): begin
          mux_sel = MUX_PC;
          ir_load = 1'b1;
          ar_load = 1'b1;
        end
        T_W'(3): begin
          if (op_fetch) begin
            mem_step = 1'b1;
            if (mem_ok) begin
              mux_sel = MUX_MEM;
              dr_load = 1'b1;
              pc_inc  = 1'b1;
            end
          end else if (is_coma) begin
            alu_op  = ALU_COM;
            ac_load = 1'b1;
            zc_load = 1'b1;
            clear   = 1'b1;
          end else if (is_hlt) begin
            halted_d = 1'b1;
            clear    = 1'b1;
          end else begin
            illegal = 1'b1;
            clear   = 1'b1;
          end
        end
        T_W'(4): begin
          if (is_jmp || (is_cj && cj_take)) begin
            mux_sel = MUX_DR;
            pc_load = 1'b1;
            clear   = 1'b1;
          end else if (is_cj) begin
            clear = 1'b1;
          end else if (is_lda || is_adda || is_stoa) begin
            mux_sel = MUX_DR;
            ar_load = 1'b1;
          end else begin
            clear = 1'b1;
          end
        end
        T_W'(5): begin
          if (is_lda || is_adda) begin
            mem_step = 1'b1;
            if (mem_ok) begin
              mux_sel = MUX_MEM;
              dr_load = 1'b1;
            end
          end else if (is_stoa) begin
            mem_step = 1'b1;
            if (mem_ok) begin
              mux_sel = MUX_ACC;
              mem_we  = 1'b1;
              clear   = 1'b1;
            end
          end else begin
            clear = 1'b1;
          end
        end
        T_W'(6): begin
          if (is_lda || is_adda) begin
            mux_sel = MUX_DR;
            alu_op  = is_lda ? ALU_PAS : ALU_ADD;
            ac_load = 1'b1;
            zc_load = 1'b1;
          end
          clear = 1'b1;
        end
        default: clear = 1'b1;
      endcase
    end

    if (halted_q || (mem_step && !mem_ok)) begin
      t_d = t_q;
    end else if (clear) begin
      t_d = '0;
    end else begin
      t_d = t_q + T_W'(1);
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      t_q      <= '0;
      halted_q <= 1'b0;
    end else begin
      t_q      <= t_d;
      halted_q <= halted_d;
    end
  end

  assign bus.MUX_sel     = mux_sel;
  assign bus.ALU_op      = alu_op;
  assign bus.AR_load     = ar_load;
  assign bus.PC_load     = pc_load;
  assign bus.PC_inc      = pc_inc;
  assign bus.AC_load     = ac_load;
  assign bus.ZC_load     = zc_load;
  assign bus.IR_load     = ir_load;
  assign bus.DR_load     = dr_load;
  assign bus.MEM_we      = mem_we;
  assign bus.halted      = halted_q;
  assign bus.illegal     = illegal;
  assign bus.state_count = t_q;
  assign bus.clear       = clear;

endmodule

// File: tb/tb_control_seq.sv
// Table-driven bench for control_seq: vectors queued with expectations, sampled on the rising edge.
module tb_control_seq;
  localparam logic [1:0] M_ACC = 2'b00;
  localparam logic [1:0] M_DR  = 2'b01;
  localparam logic [1:0] M_PC  = 2'b10;
  localparam logic [1:0] M_MEM = 2'b11;
  localparam logic [1:0] A_ADD = 2'b00;
  localparam logic [1:0] A_PAS = 2'b01;
  localparam logic [1:0] A_COM = 2'b11;
  // strobe mask order: AR, PC_load, PC_inc, AC, ZC, IR, DR, MEM_we
  localparam logic [7:0] S_AR  = 8'h80;
  localparam logic [7:0] S_PCL = 8'h40;
  localparam logic [7:0] S_PCI = 8'h20;
  localparam logic [7:0] S_AC  = 8'h10;
  localparam logic [7:0] S_ZC  = 8'h08;
  localparam logic [7:0] S_IR  = 8'h04;
  localparam logic [7:0] S_DR  = 8'h02;
  localparam logic [7:0] S_WE  = 8'h01;

  typedef struct {
    logic [7:0]  instr;
    logic        fz;
    logic        fc;
    logic        mr;
    logic [17:0] exp;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  vec_t tbl[$];
  logic [17:0] exp_q[$];

  control_seq_if #(.OPC_W(8), .T_W(3)) bus ();

  control_seq #(.OPC_W(8), .T_W(3), .MEM_WAIT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  function automatic logic [17:0] pk(input int t, input logic [1:0] mux, input logic [1:0] alu,
                                     input logic [7:0] s, input logic h, input logic il,
                                     input logic cl);
    return {3'(t), mux, alu, s, h, il, cl};
  endfunction

  function automatic logic [17:0] obs();
    return {bus.state_count, bus.MUX_sel, bus.ALU_op, bus.AR_load, bus.PC_load, bus.PC_inc,
            bus.AC_load, bus.ZC_load, bus.IR_load, bus.DR_load, bus.MEM_we,
            bus.halted, bus.illegal, bus.clear};
  endfunction

  function automatic vec_t mkv(input logic [7:0] op, input logic fz, input logic fc,
                               input logic mr, input int t, input logic [1:0] mux,
                               input logic [1:0] alu, input logic [7:0] s, input logic h,
                               input logic il, input logic cl);
    vec_t v;
    v.instr = op;
    v.fz    = fz;
    v.fc    = fc;
    v.mr    = mr;
    v.exp   = pk(t, mux, alu, s, h, il, cl);
    return v;
  endfunction

  task automatic add(input vec_t v);
    tbl.push_back(v);
  endtask

  task automatic add_fetch(input logic [7:0] op);
    add(mkv(op, 0, 0, 1, 0, M_PC,  A_ADD, S_AR,         0, 0, 0));
    add(mkv(op, 0, 0, 1, 1, M_MEM, A_ADD, S_DR | S_PCI, 0, 0, 0));
    add(mkv(op, 0, 0, 1, 2, M_PC,  A_ADD, S_IR | S_AR,  0, 0, 0));
  endtask

  task automatic add_t3mem(input logic [7:0] op, input logic fz, input logic fc);
    add(mkv(op, fz, fc, 1, 3, M_MEM, A_ADD, S_DR | S_PCI, 0, 0, 0));
  endtask

  task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    logic [17:0] e;
    bus.Instruction = v.instr;
    bus.flag_z      = v.fz;
    bus.flag_c      = v.fc;
    bus.mem_ready   = v.mr;
    exp_q.push_back(v.exp);
    @(posedge clk);
    e = exp_q.pop_front();
    check(name, obs(), e);
    checks++;
    if (bus.PC_load && bus.PC_inc) begin
      failures++;
      $display("FAIL %s_pc_excl got=both want=at_most_one", name);
    end
    @(negedge clk);
    #1;
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    rst             = 1'b0;
    bus.Instruction = 8'h00;
    bus.flag_z      = 1'b0;
    bus.flag_c      = 1'b0;
    bus.mem_ready   = 1'b1;

    // LDA: full seven-step instruction
    add_fetch(8'h00);
    add_t3mem(8'h00, 0, 0);
    add(mkv(8'h00, 0, 0, 1, 4, M_DR,  A_ADD, S_AR,        0, 0, 0));
    add(mkv(8'h00, 0, 0, 1, 5, M_MEM, A_ADD, S_DR,        0, 0, 0));
    add(mkv(8'h00, 1, 1, 1, 6, M_DR,  A_PAS, S_AC | S_ZC, 0, 0, 1));
    // ADDA with a three-cycle memory wait at T5
    add_fetch(8'h01);
    add_t3mem(8'h01, 0, 0);
    add(mkv(8'h01, 0, 0, 1, 4, M_DR,  A_ADD, S_AR,        0, 0, 0));
    for (int i = 0; i < 3; i++) add(mkv(8'h01, 0, 0, 0, 5, M_ACC, A_ADD, 8'h00, 0, 0, 0));
    add(mkv(8'h01, 0, 0, 1, 5, M_MEM, A_ADD, S_DR,        0, 0, 0));
    add(mkv(8'h01, 0, 0, 1, 6, M_DR,  A_ADD, S_AC | S_ZC, 0, 0, 1));
    // COMA: four steps, no PC_inc at T3
    add_fetch(8'h04);
    add(mkv(8'h04, 0, 0, 1, 3, M_ACC, A_COM, S_AC | S_ZC, 0, 0, 1));
    // STOA with waits at T1 and T5
    add(mkv(8'h02, 0, 0, 1, 0, M_PC,  A_ADD, S_AR,         0, 0, 0));
    add(mkv(8'h02, 0, 0, 0, 1, M_ACC, A_ADD, 8'h00,        0, 0, 0));
    add(mkv(8'h02, 0, 0, 1, 1, M_MEM, A_ADD, S_DR | S_PCI, 0, 0, 0));
    add(mkv(8'h02, 0, 0, 1, 2, M_PC,  A_ADD, S_IR | S_AR,  0, 0, 0));
    add_t3mem(8'h02, 0, 0);
    add(mkv(8'h02, 0, 0, 1, 4, M_DR,  A_ADD, S_AR,         0, 0, 0));
    add(mkv(8'h02, 0, 0, 0, 5, M_ACC, A_ADD, 8'h00,        0, 0, 0));
    add(mkv(8'h02, 0, 0, 1, 5, M_ACC, A_ADD, S_WE,         0, 0, 1));
    // JMP
    add_fetch(8'h03);
    add_t3mem(8'h03, 0, 0);
    add(mkv(8'h03, 0, 0, 1, 4, M_DR, A_ADD, S_PCL, 0, 0, 1));
    // undefined opcodes, including one that matches LDA in its low bits
    add_fetch(8'hFF);
    add(mkv(8'hFF, 0, 0, 1, 3, M_ACC, A_ADD, 8'h00, 0, 1, 1));
    add_fetch(8'h08);
    add(mkv(8'h08, 0, 0, 1, 3, M_ACC, A_ADD, 8'h00, 0, 1, 1));
`ifdef CTRL_COND_JUMP_EN
    add_fetch(8'h05);
    add_t3mem(8'h05, 1, 0);
    add(mkv(8'h05, 1, 0, 1, 4, M_DR,  A_ADD, S_PCL, 0, 0, 1));
    add_fetch(8'h05);
    add_t3mem(8'h05, 0, 1);
    add(mkv(8'h05, 0, 1, 1, 4, M_ACC, A_ADD, 8'h00, 0, 0, 1));
    add_fetch(8'h06);
    add_t3mem(8'h06, 0, 1);
    add(mkv(8'h06, 0, 1, 1, 4, M_DR,  A_ADD, S_PCL, 0, 0, 1));
`else
    add_fetch(8'h05);
    add(mkv(8'h05, 1, 0, 1, 3, M_ACC, A_ADD, 8'h00, 0, 1, 1));
    add_fetch(8'h06);
    add(mkv(8'h06, 0, 1, 1, 3, M_ACC, A_ADD, 8'h00, 0, 1, 1));
`endif

    // reset state: T0 strobes only while rst is low
    @(negedge clk);
    #1;
    @(posedge clk);
    check("reset_state", obs(), pk(0, M_PC, A_ADD, S_AR, 0, 0, 0));
    @(negedge clk);
    #1;
    rst = 1'b1;

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("tbl%0d", i));

    // HLT: halts after T3, then frozen with all strobes low
    run_vec(mkv(8'h07, 0, 0, 1, 0, M_PC,  A_ADD, S_AR,         0, 0, 0), "hlt_t0");
    run_vec(mkv(8'h07, 0, 0, 1, 1, M_MEM, A_ADD, S_DR | S_PCI, 0, 0, 0), "hlt_t1");
    run_vec(mkv(8'h07, 0, 0, 1, 2, M_PC,  A_ADD, S_IR | S_AR,  0, 0, 0), "hlt_t2");
    run_vec(mkv(8'h07, 0, 0, 1, 3, M_ACC, A_ADD, 8'h00,        0, 0, 1), "hlt_t3");
    for (int i = 0; i < 20; i++) begin
      logic [2:0] r;
      r = 3'($urandom_range(0, 7));
      run_vec(mkv(8'h07, r[0], r[1], r[2], 0, M_ACC, A_ADD, 8'h00, 1, 0, 0),
              $sformatf("halted%0d", i));
    end
    rst = 1'b0;
    #1;
    check("hlt_rst", obs(), pk(0, M_PC, A_ADD, S_AR, 0, 0, 0));
    @(negedge clk);
    #1;
    rst = 1'b1;

    // STOA interrupted by reset during its T5 memory wait
    run_vec(mkv(8'h02, 0, 0, 1, 0, M_PC,  A_ADD, S_AR,         0, 0, 0), "sr_t0");
    run_vec(mkv(8'h02, 0, 0, 1, 1, M_MEM, A_ADD, S_DR | S_PCI, 0, 0, 0), "sr_t1");
    run_vec(mkv(8'h02, 0, 0, 1, 2, M_PC,  A_ADD, S_IR | S_AR,  0, 0, 0), "sr_t2");
    run_vec(mkv(8'h02, 0, 0, 1, 3, M_MEM, A_ADD, S_DR | S_PCI, 0, 0, 0), "sr_t3");
    run_vec(mkv(8'h02, 0, 0, 1, 4, M_DR,  A_ADD, S_AR,         0, 0, 0), "sr_t4");
    run_vec(mkv(8'h02, 0, 0, 0, 5, M_ACC, A_ADD, 8'h00,        0, 0, 0), "sr_wait0");
    run_vec(mkv(8'h02, 0, 0, 0, 5, M_ACC, A_ADD, 8'h00,        0, 0, 0), "sr_wait1");
    #2;
    rst = 1'b0;
    #1;
    check("sr_async", obs(), pk(0, M_PC, A_ADD, S_AR, 0, 0, 0));
    bus.mem_ready = 1'b1;
    @(posedge clk);
    check("sr_hold", obs(), pk(0, M_PC, A_ADD, S_AR, 0, 0, 0));
    @(negedge clk);
    check("sr_edge", obs(), pk(0, M_PC, A_ADD, S_AR, 0, 0, 0));
    #1;
    rst = 1'b1;
    run_vec(mkv(8'h02, 0, 0, 1, 0, M_PC,  A_ADD, S_AR,         0, 0, 0), "sr_rel_t0");
    run_vec(mkv(8'h02, 0, 0, 1, 1, M_MEM, A_ADD, S_DR | S_PCI, 0, 0, 0), "sr_rel_t1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
